// File: rtl/vga_scanout.sv
// Pixel sink at the end of the ppu stream: buffers stb/ack pixel bytes in a
// small FIFO and scans them out with free-running VGA timing and a frame sync.
module vga_scanout #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned FIFO_ADDR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        stb_i,
    output logic        ack_i,
    output logic        sync_o,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [1:0]  red,
    output logic [1:0]  green,
    output logic [1:0]  blue,
    output logic [15:0] underflow_cnt
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = FIFO_ADDR_BITS + 1;

    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    logic [HW-1:0]             hcount_q, hcount_d;
    logic [VW-1:0]             vcount_q, vcount_d;
    logic [5:0]                mem_q [FIFO_DEPTH];
    logic [5:0]                mem_d [FIFO_DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ack_q, ack_d;
    logic                      sync_q, sync_d;
    logic                      hsync_q, hsync_d;
    logic                      vsync_q, vsync_d;
    logic                      de_q, de_d;
    logic [5:0]                rgb_q, rgb_d;
    logic [15:0]               underflow_q, underflow_d;

    logic active, h_last, v_last, push, pop;
    logic unused_pad_bits;

    assign unused_pad_bits = ^data_i[1:0];

    always_comb begin
        active = (hcount_q < H_ACT_END) && (vcount_q < V_ACT_END);
        h_last = (hcount_q == H_LAST);
        v_last = (vcount_q == V_LAST);
        // Full test looks only at the registered count: no credit for a same-cycle pop.
        push   = stb_i && (count_q < FULL);
        pop    = active && (count_q != '0);

        hcount_d = h_last ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + 1'b1;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i[7:2];
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        ack_d   = push;
        sync_d  = h_last && v_last;
        de_d    = active;
        hsync_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
        vsync_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
        rgb_d   = pop ? mem_q[rd_ptr_q] : '0;

        underflow_d = underflow_q;
        if (active && (count_q == '0) && (underflow_q != '1)) begin
            underflow_d = underflow_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            sync_q      <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= '0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            sync_q      <= sync_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign ack_i         = ack_q;
    assign sync_o        = sync_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign de            = de_q;
    assign red           = rgb_q[5:4];
    assign green         = rgb_q[3:2];
    assign blue          = rgb_q[1:0];
    assign underflow_cnt = underflow_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with shrunken timing so whole frames and counter
// saturation fit in a short run; a queue/cycle-arithmetic model checks every cycle.
module tb_vga_scanout;
    localparam int unsigned H_ACT  = 240;
    localparam int unsigned H_FP   = 2;
    localparam int unsigned H_SYNC = 4;
    localparam int unsigned H_BP   = 2;
    localparam int unsigned V_ACT  = 60;
    localparam int unsigned V_FP   = 1;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 1;
    localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME  = H_TOT * V_TOT;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AA_BASE = 244;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_i;
    logic        stb_i;
    logic        ack_i, sync_o, hsync, vsync, de;
    logic [1:0]  red, green, blue;
    logic [15:0] underflow_cnt;
    logic [5:0]  rgb;

    assign rgb = {red, green, blue};

    vga_scanout #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FIFO_DEPTH(DEPTH), .FIFO_ADDR_BITS(2)
    ) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .stb_i(stb_i), .ack_i(ack_i),
        .sync_o(sync_o), .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input int unsigned i);
        logic [7:0] tbl [4];
        tbl = '{8'hC0, 8'h30, 8'h0C, 8'hFC};
        if (i < 4) return tbl[i[1:0]];
        if (i >= AA_BASE) return 8'hAA;
        return 8'(i * 37 + 5);
    endfunction

    // Producer holds each byte until it sees the ack for it.
    int unsigned tx_rd  = 0;
    int unsigned tx_lim = 0;
    always @(negedge clk) if (ack_i) tx_rd <= tx_rd + 1;
    assign stb_i  = (tx_rd < tx_lim);
    assign data_i = byte_at(tx_rd);

    // Model: screen position from the cycle index, FIFO as a queue.
    int unsigned t;
    int unsigned m_h, m_v;
    logic        m_act;
    logic [7:0]  mq [$];
    logic        exp_ack, exp_sync, exp_hs, exp_vs, exp_de;
    logic [5:0]  exp_rgb;
    logic [15:0] exp_uf;

    always_comb begin
        m_h   = t % H_TOT;
        m_v   = (t / H_TOT) % V_TOT;
        m_act = (m_h < H_ACT) && (m_v < V_ACT);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t <= 0;
            mq.delete();
            exp_ack <= 1'b0; exp_sync <= 1'b0; exp_de <= 1'b0;
            exp_hs  <= 1'b1; exp_vs   <= 1'b1;
            exp_rgb <= '0;   exp_uf   <= '0;
        end else begin
            exp_ack  <= stb_i && (mq.size() < DEPTH);
            exp_de   <= m_act;
            exp_hs   <= !(m_h >= H_ACT + H_FP && m_h < H_ACT + H_FP + H_SYNC);
            exp_vs   <= !(m_v >= V_ACT + V_FP && m_v < V_ACT + V_FP + V_SYNC);
            exp_sync <= (t % FRAME) == FRAME - 1;
            exp_rgb  <= (m_act && mq.size() > 0) ? mq[0][7:2] : 6'd0;
            if (m_act && mq.size() == 0 && exp_uf != 16'hFFFF) exp_uf <= exp_uf + 16'd1;
            if (m_act && mq.size() > 0) begin
                void'(mq.pop_front());
                if (stb_i && mq.size() < DEPTH - 1) mq.push_back(data_i);
            end else if (stb_i && mq.size() < DEPTH) begin
                mq.push_back(data_i);
            end
            t <= t + 1;
        end
    end

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int          seg     = 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s seg=%0d t=%0d: got %0h, expected %0h", name, seg, t, act, exp);
    endtask

    always @(negedge clk or negedge rst) begin
        #1;
        if (!rst) begin
            chk("rst_hsync", 32'(hsync), 1);
            chk("rst_vsync", 32'(vsync), 1);
            chk("rst_de", 32'(de), 0);
            chk("rst_rgb", 32'(rgb), 0);
            chk("rst_ack", 32'(ack_i), 0);
            chk("rst_sync", 32'(sync_o), 0);
            chk("rst_uf", 32'(underflow_cnt), 0);
        end else begin
            chk("ack", 32'(ack_i), 32'(exp_ack));
            chk("sync", 32'(sync_o), 32'(exp_sync));
            chk("hsync", 32'(hsync), 32'(exp_hs));
            chk("vsync", 32'(vsync), 32'(exp_vs));
            chk("de", 32'(de), 32'(exp_de));
            chk("rgb", 32'(rgb), 32'(exp_rgb));
            chk("uf", 32'(underflow_cnt), 32'(exp_uf));
            if (seg == 1) begin
                case (t)
                    240:  begin chk("l0_uf", 32'(underflow_cnt), 240); chk("l0_de_last", 32'(de), 1); end
                    241:  begin chk("l0_de_off", 32'(de), 0); chk("fill_ack0", 32'(ack_i), 1); end
                    244:  chk("fill_ack3", 32'(ack_i), 1);
                    245:  chk("full_noack", 32'(ack_i), 0);
                    249:  begin
                              chk("px0_rgb", 32'(rgb), 32'h30);
                              chk("model_px0", 32'(exp_rgb), 32'h30);
                              chk("px0_noack", 32'(ack_i), 0);
                              chk("px0_uf", 32'(underflow_cnt), 240);
                          end
                    250:  begin chk("px1_rgb", 32'(rgb), 32'h0C); chk("px1_ack", 32'(ack_i), 1); end
                    251:  chk("px2_rgb", 32'(rgb), 32'h03);
                    252:  chk("px3_rgb", 32'(rgb), 32'h3F);
                    737:  chk("aa_ack0", 32'(ack_i), 1);
                    740:  chk("aa_ack3", 32'(ack_i), 1);
                    741:  chk("aa_full0", 32'(ack_i), 0);
                    745:  begin chk("aa_full4", 32'(ack_i), 0); chk("aa_rgb", 32'(rgb), 32'h2A); end
                    746:  chk("aa_resume", 32'(ack_i), 1);
                    1240: chk("uf_line5_start", 32'(underflow_cnt), 712);
                    1300: begin chk("empty_rgb", 32'(rgb), 0); chk("empty_de", 32'(de), 1); end
                    1480: chk("uf_line5_end", 32'(underflow_cnt), 952);
                    default: ;
                endcase
            end else begin
                case (t)
                    1:     begin chk("post_rst_rgb", 32'(rgb), 0); chk("post_rst_de", 32'(de), 1); end
                    242:   chk("hs_pre", 32'(hsync), 1);
                    243:   chk("hs_first", 32'(hsync), 0);
                    246:   chk("hs_last", 32'(hsync), 0);
                    247:   chk("hs_post", 32'(hsync), 1);
                    15128: chk("vs_pre", 32'(vsync), 1);
                    15129: chk("vs_first", 32'(vsync), 0);
                    15624: chk("vs_last", 32'(vsync), 0);
                    15625: chk("vs_post", 32'(vsync), 1);
                    15871: chk("sync_pre", 32'(sync_o), 0);
                    15872: begin chk("sync_f1", 32'(sync_o), 1); chk("model_sync", 32'(exp_sync), 1); end
                    15873: chk("sync_post", 32'(sync_o), 0);
                    31744: chk("sync_f2", 32'(sync_o), 1);
                    71686: chk("uf_near_sat", 32'(underflow_cnt), 32'hFFFE);
                    71687: begin chk("uf_sat", 32'(underflow_cnt), 32'hFFFF); chk("model_sat", 32'(exp_uf), 32'hFFFF); end
                    72500: chk("uf_hold", 32'(underflow_cnt), 32'hFFFF);
                    default: ;
                endcase
            end
        end
    end

    task automatic wait_t(input int unsigned n);
        while (t != n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_t(240);
        tx_lim = 244;
        wait_t(736);
        tx_lim = 488;
        wait_t(1976);
        tx_lim = 1488;
        wait_t(2084);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        tx_lim = tx_rd;
        repeat (3) @(negedge clk);
        seg = 2;
        rst = 1'b1;
        wait_t(72600);
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Pixel sink at the downstream end of the ppu output stream.
- Responder side of the stb/ack byte handshake: accepts pixel bytes (RRGGBBxx) into a small FIFO.
- Generates 640x480@60 VGA timing (800x525 totals) and drives 2-bit-per-channel RGB, hsync and vsync.
- Emits a one-cycle frame sync so the ppu's sx/sy counters stay aligned to scanout.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse lines
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- FIFO_DEPTH, 4, pixel FIFO entries
- FIFO_ADDR_BITS, 2, log2(FIFO_DEPTH)

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst  in  1  asynchronous, active-low reset
- data_i  in  8  pixel byte: [7:6] R, [5:4] G, [3:2] B, [1:0] ignored
- stb_i  in  1  producer strobe, data_i valid
- ack_i  out  1  byte accepted on previous edge
- sync_o  out  1  frame-wrap pulse to the producer's sync input
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  display enable (active video)
- red  out  2  red channel
- green  out  2  green channel
- blue  out  2  blue channel
- underflow_cnt  out  16  saturating count of active pixels shown with the FIFO empty

Behaviour:
- Reset (async, rst=0) values:
  - hcount = 0, vcount = 0; FIFO empty (count 0, pointers 0).
  - ack_i = 0, sync_o = 0, de = 0, red/green/blue = 0.
  - hsync = 1, vsync = 1 (inactive), underflow_cnt = 0.
- Counters:
  - hcount runs 0..799 and wraps to 0.
  - vcount increments when hcount == 799, runs 0..524 and wraps to 0.
- Input handshake:
  - On an edge with stb_i = 1 and FIFO count < FIFO_DEPTH, push data_i; ack_i = 1 for the following cycle.
  - Otherwise ack_i = 0.
  - One byte per cycle is sustainable.
  - Full test uses the registered count only; there is no same-cycle pop credit.
  - If stb_i = 1 while full: no push, ack_i = 0. The producer holds data until acked.
- Pixel pop:
  - When hcount < H_ACTIVE and vcount < V_ACTIVE (active), pop one entry per cycle if count > 0.
  - If count = 0 in active: output black and increment underflow_cnt, saturating at 16'hFFFF.
  - No push-to-pop bypass: a byte pushed in the same cycle is not displayed in that cycle.
  - The FIFO is never popped outside active.
- Count update per edge: +1 (push only), -1 (pop only), 0 (both or neither).
- Outputs are registered with 1 cycle of latency from counter state:
  - de <= active.
  - hsync <= !(656 <= hcount <= 751).
  - vsync <= !(490 <= vcount <= 491).
  - {red, green, blue} <= popped byte [7:2] when active and non-empty, else 0.
- Sync output:
  - sync_o <= 1 on the edge where (hcount, vcount) = (799, 524); 0 otherwise.
  - sync_o is high for exactly one cycle per 420000-cycle frame.
  - The producer's counters reset on the same edge on which ours wrap to (0, 0).
- Reset mid-frame:
  - All state returns to reset values immediately and asynchronously.
  - FIFO contents are discarded; the in-flight ack is dropped.
- No FSM beyond counters and the FIFO. Timing is free-running and independent of FIFO state.

Test Plan:
1. Reset with stb_i = 0 -> hsync = vsync = 1, de = 0, RGB = 0, underflow_cnt = 0. After release: hsync low for exactly 96 cycles every 800; vsync low for exactly 1600 cycles every 420000; de high 640 cycles per line on 480 lines.
2. Pre-fill 4 bytes 0xC0, 0x30, 0x0C, 0xFC in blanking, then stream continuously -> first active outputs (R,G,B) = (3,0,0), (0,3,0), (0,0,3), (3,3,3). ack_i pulses once per byte; underflow_cnt stays 0.
3. Hold stb_i = 1 with data 0xAA through horizontal blanking with no pops -> exactly 4 ack_i pulses, then ack_i stays 0 until active starts. From then on, one ack per popped pixel.
4. stb_i = 0 for a whole line -> de high 640 cycles with RGB = 0 and underflow_cnt = 640. Run a full empty frame -> underflow_cnt = 0xFFFF (saturated).
5. Free-run two frames -> sync_o high exactly one cycle per frame, at (hcount, vcount) = (799, 524). Pulses are 420000 cycles apart.
6. Assert rst at hcount = 300, vcount = 100 with the FIFO holding 3 bytes -> outputs return to reset values at once. After release: count = 0, the next hsync low occurs 656 cycles later, and no stale bytes are displayed.
